// File: rtl/rx_pkg.sv
// rx_pkg: shared types, widths and header field layout for the rx capture path
package rx_pkg;
  localparam int DATAW = 32;
  localparam int SMPW = 16;
  localparam int AW = 9;
  localparam int HDR_IDX_W = 16;
  localparam int HDR_SMP_W = 16;
  typedef enum logic [1:0] {IDLE, CAPT, DRAIN} state_t;
endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: first-word-fall-through FIFO of 2^AW entries; set_last marks the newest stored entry as last
module rx_fifo #(
  parameter int W = 33,
  parameter int AW = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         set_last,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0] wlast;
  logic do_push, do_pop;
  // flags and pointer advance; a pop on the same cycle frees room for a push even when full
  always_comb begin
    full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty = wptr_q == rptr_q;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d = wptr_q + (AW+1)'(do_push);
    rptr_d = rptr_q + (AW+1)'(do_pop);
    wlast = wptr_q[AW-1:0] - AW'(1);
    dout = empty ? '0 : mem[rptr_q[AW-1:0]];
  end
  // pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  // storage; set_last only occurs on a cycle whose push was dropped
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= din;
    if (set_last) mem[wlast][W-1] <= 1'b1;
  end
endmodule

// File: rtl/rx_ctrl.sv
// rx_ctrl: captures rxsmps ADC words per trig into an AXI4-Stream packet; RX_HDR_EN adds a header beat
module rx_ctrl
  import rx_pkg::*;
#(
  parameter int DATAW = rx_pkg::DATAW,
  parameter int SMPW = rx_pkg::SMPW,
  parameter int AW = rx_pkg::AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [SMPW-1:0]  rxsmps,
  input  logic [DATAW-1:0] adc_0,
  output logic [DATAW-1:0] rx_tdata,
  output logic             rx_tvalid,
  output logic             rx_tlast,
  input  logic             rx_tready,
  output logic             busy,
  output logic             overflow
);
  state_t state_q, state_d;
  logic [SMPW-1:0] cnt_q, cnt_d, n_q, n_d;
  logic ovf_q, ovf_d;
  logic start, capt, is_last, hs, full, empty, push, drop;
  logic [DATAW:0] din, dout;
`ifdef RX_HDR_EN
  logic [HDR_IDX_W-1:0] idx_q, idx_d;
`endif
  // next state, sample counter, sticky overflow and FIFO write control
  always_comb begin
    hs = !empty && rx_tready;
    start = (state_q == IDLE) && trig && (rxsmps != '0);
    capt = state_q == CAPT;
    is_last = cnt_q == n_q - SMPW'(1);
    drop = capt && full && !hs;
`ifdef RX_HDR_EN
    push = capt || start;
    din = start ? {1'b0, DATAW'({idx_q, rxsmps[HDR_SMP_W-1:0]})} : {is_last, adc_0};
    idx_d = start ? idx_q + HDR_IDX_W'(1) : idx_q;
`else
    push = capt;
    din = {is_last, adc_0};
`endif
    state_d = start ? CAPT : (capt && is_last) ? DRAIN : (state_q == DRAIN && hs && dout[DATAW]) ? IDLE : state_q;
    cnt_d = start ? '0 : capt ? cnt_q + SMPW'(1) : cnt_q;
    n_d = start ? rxsmps : n_q;
    ovf_d = start ? 1'b0 : drop ? 1'b1 : ovf_q;
  end
  // control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      ovf_q <= 1'b0;
`ifdef RX_HDR_EN
      idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      ovf_q <= ovf_d;
`ifdef RX_HDR_EN
      idx_q <= idx_d;
`endif
    end
  end
  rx_fifo #(.W(DATAW + 1), .AW(AW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(hs),
    .set_last(drop && is_last), .dout(dout), .full(full), .empty(empty)
  );
  assign rx_tdata = dout[DATAW-1:0];
  assign rx_tlast = dout[DATAW];
  assign rx_tvalid = !empty;
  assign busy = state_q != IDLE;
  assign overflow = ovf_q;
endmodule
